// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display driver.
//   segment_t   : active-low segment patterns (bit 7 = decimal point, always off)
//   ANODE_*     : one-cold anode selects for each digit position
//   DIGIT_MAX   : largest magnitude that fits on three decimal digits
//   drv_state_t : driver control states
//   bcd_to_seg  : BCD nibble to segment pattern
package seg7_pkg;

    typedef enum logic [7:0] {
        SEG_0     = 8'hC0,
        SEG_1     = 8'hF9,
        SEG_2     = 8'hA4,
        SEG_3     = 8'hB0,
        SEG_4     = 8'h99,
        SEG_5     = 8'h92,
        SEG_6     = 8'h82,
        SEG_7     = 8'hF8,
        SEG_8     = 8'h80,
        SEG_9     = 8'h90,
        SEG_E     = 8'h86,
        SEG_MINUS = 8'hBF,
        SEG_BLANK = 8'hFF
    } segment_t;

    localparam logic [3:0] ANODE_ONES     = 4'b1110;
    localparam logic [3:0] ANODE_TENS     = 4'b1101;
    localparam logic [3:0] ANODE_HUNDREDS = 4'b1011;
    localparam logic [3:0] ANODE_SIGN     = 4'b0111;

    localparam int unsigned DIGIT_MAX = 999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_UPDATE
    } drv_state_t;

    function automatic segment_t bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin and begin a conversion (ignored bits beyond three digits)
//   bin        : VALUE_WIDTH-bit unsigned input
//   done       : high during the final shift cycle; digits valid from the next cycle
//   ones/tens/hundreds : BCD result, held until the next start
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [VALUE_WIDTH-1:0] bin,
    output logic                   done,
    output logic [3:0]             ones,
    output logic [3:0]             tens,
    output logic [3:0]             hundreds
);

    localparam int unsigned CW = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(VALUE_WIDTH - 1);

    logic                   busy;
    logic [CW-1:0]          count;
    logic [VALUE_WIDTH-1:0] shreg;
    logic [11:0]            bcd;
    logic [11:0]            bcd_adj;

    // Add-3 correction on every nibble that would overflow decimal after the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            count <= '0;
            shreg <= '0;
            bcd   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            shreg <= bin;
            bcd   <= '0;
        end else if (busy) begin
            {bcd, shreg} <= {bcd_adj[10:0], shreg, 1'b0};
            count        <= count + CW'(1);
            if (count == LAST) begin
                busy <= 1'b0;
            end
        end
    end

    assign done     = busy && (count == LAST);
    assign ones     = bcd[3:0];
    assign tens     = bcd[7:4];
    assign hundreds = bcd[11:8];

endmodule

// File: rtl/seg7_display_driver.sv
// Four-digit multiplexed seven-segment driver for a signed result or error.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : display request, accepted when load && ready
//   value      : signed (two's complement) result
//   error      : show the error pattern instead of value
//   ready      : idle and able to accept a load
//   anodes     : active-low digit select, one bit low
//   segments   : active-low segment pattern for the selected digit
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros and the
// sign digit of non-negative/error displays.
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH   = 9,
    parameter int unsigned DIVIDER_WIDTH = 12,
    parameter int unsigned ANODE_WIDTH   = 4,
    parameter int unsigned SEGMENT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic signed [VALUE_WIDTH-1:0] value,
    input  logic                          error,
    output logic                          ready,
    output logic [ANODE_WIDTH-1:0]        anodes,
    output logic [SEGMENT_WIDTH-1:0]      segments
);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam segment_t PAD_SEG = SEG_BLANK;
`else
    localparam segment_t PAD_SEG = SEG_0;
`endif

    drv_state_t state, state_n;

    logic                   conv_start;
    logic                   conv_done;
    logic [VALUE_WIDTH-1:0] magnitude;
    logic [3:0]             bcd_ones, bcd_tens, bcd_hund;

    logic                   pend_err, pend_neg;

    logic [3:0]             disp_ones, disp_tens, disp_hund;
    logic                   disp_neg, disp_err;
    logic [3:0]             disp_ones_n, disp_tens_n, disp_hund_n;
    logic                   disp_neg_n, disp_err_n;

    logic [DIVIDER_WIDTH-1:0] divider;
    logic [1:0]               scan_idx, scan_idx_n;
    logic [3:0]               anode_n;
    segment_t                 seg_n;

    // Most negative input maps to its true magnitude (e.g. -256 -> 256).
    assign magnitude = value[VALUE_WIDTH-1] ? $unsigned(-value) : $unsigned(value);

    bin2bcd_seq #(
        .VALUE_WIDTH(VALUE_WIDTH)
    ) u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (conv_start),
        .bin      (magnitude),
        .done     (conv_done),
        .ones     (bcd_ones),
        .tens     (bcd_tens),
        .hundreds (bcd_hund)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        ready      = 1'b0;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (load) begin
                    conv_start = 1'b1;
                    state_n    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    state_n = ST_UPDATE;
                end
            end
            ST_UPDATE: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_err <= 1'b0;
            pend_neg <= 1'b0;
        end else if (conv_start) begin
            pend_err <= error || (32'(magnitude) > DIGIT_MAX);
            pend_neg <= value[VALUE_WIDTH-1];
        end
    end

    // Held digits change only in UPDATE so the display never shows a partial result.
    // Error forces the digits to zero so tens/hundreds render as pad digits.
    always_comb begin
        disp_ones_n = disp_ones;
        disp_tens_n = disp_tens;
        disp_hund_n = disp_hund;
        disp_neg_n  = disp_neg;
        disp_err_n  = disp_err;
        if (state == ST_UPDATE) begin
            disp_err_n  = pend_err;
            disp_neg_n  = pend_neg && !pend_err;
            disp_ones_n = pend_err ? 4'd0 : bcd_ones;
            disp_tens_n = pend_err ? 4'd0 : bcd_tens;
            disp_hund_n = pend_err ? 4'd0 : bcd_hund;
        end
    end

    assign scan_idx_n = (divider == '1) ? scan_idx + 2'd1 : scan_idx;

    // Outputs are decoded from next-state values so anodes, segments and a
    // freshly written digit all appear on the same edge.
    always_comb begin
        anode_n = ANODE_ONES;
        seg_n   = SEG_0;
        case (scan_idx_n)
            2'd0: begin
                anode_n = ANODE_ONES;
                seg_n   = disp_err_n ? SEG_E : bcd_to_seg(disp_ones_n);
            end
            2'd1: begin
                anode_n = ANODE_TENS;
                seg_n   = (disp_hund_n == 4'd0 && disp_tens_n == 4'd0) ? PAD_SEG
                                                                        : bcd_to_seg(disp_tens_n);
            end
            2'd2: begin
                anode_n = ANODE_HUNDREDS;
                seg_n   = (disp_hund_n == 4'd0) ? PAD_SEG : bcd_to_seg(disp_hund_n);
            end
            default: begin
                anode_n = ANODE_SIGN;
                seg_n   = disp_neg_n ? SEG_MINUS : PAD_SEG;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider   <= '0;
            scan_idx  <= '0;
            anodes    <= ANODE_WIDTH'(ANODE_ONES);
            segments  <= SEGMENT_WIDTH'(SEG_0);
            disp_ones <= '0;
            disp_tens <= '0;
            disp_hund <= '0;
            disp_neg  <= 1'b0;
            disp_err  <= 1'b0;
        end else begin
            divider   <= divider + DIVIDER_WIDTH'(1);
            scan_idx  <= scan_idx_n;
            anodes    <= ANODE_WIDTH'(anode_n);
            segments  <= SEGMENT_WIDTH'(seg_n);
            disp_ones <= disp_ones_n;
            disp_tens <= disp_tens_n;
            disp_hund <= disp_hund_n;
            disp_neg  <= disp_neg_n;
            disp_err  <= disp_err_n;
        end
    end

endmodule
